bcd_seg_display: RTL and testbench
==================================

Name: bcd_seg_display

Overview:
Sequential binary-to-BCD converter with a multi-digit seven-segment driver, used by the DE10-Lite top levels.
- Replaces per-lab combinational converters with one block parametrised in input width and digit count.
- Uses an iterative shift-add-3 (double-dabble) engine with a start/ready/done handshake.
- Adds leading-zero blanking and overflow indication.
- Feeds the board HEX0..HEX5 buses directly, one 8-bit byte per digit.

Parameters:
BIN_W, 16, width of the unsigned binary input (2..32)
DIGITS, 5, number of BCD digits / seven-segment displays driven (1..8)

Ports:
MAX10_CLK1_50  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
bin_in  input  BIN_W  binary value; sampled only on an accepted start
start  input  1  request conversion; accepted only when ready=1
blank_en  input  1  leading-zero blanking enable; sampled together with bin_in
ready  output  1  high in IDLE, i.e. a start will be accepted
done  output  1  one-cycle pulse when the outputs update
overflow  output  1  value exceeded 10^DIGITS-1 in the last conversion
bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0]
hex_out  output  8*DIGITS  packed active-low segments; digit k in bits [8k+7:8k]; bit7=DP, bit6=g .. bit0=a

Behaviour:
- Reset values: ready=1, done=0, overflow=0, bcd_out=0, hex_out all 8'hFF (all segments off). FSM goes to IDLE.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE, start=1: capture bin_in and blank_en; clear the BCD scratch register; set iteration count=BIN_W; go to SHIFT; ready drops next cycle.
  - SHIFT: each cycle, add 3 to every scratch digit >=5, then shift {scratch, binary} left by 1.
    - A 1 shifted out of the top digit sets a sticky ovf_int flag.
    - Decrement the count; go to LOAD after BIN_W SHIFT cycles.
  - LOAD: register bcd_out, hex_out and overflow; done=1 for this cycle only; go to IDLE.
- Latency: start accepted at edge N -> done high and outputs valid in cycle N+BIN_W+1. ready returns to 1 in the same cycle done is high.
- start while ready=0 is ignored, not queued. bin_in changes after acceptance do not affect the result.
- Outputs hold their values between conversions.
- Segment codes (active-low, DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank=FF, minus=BF.
- Blanking (captured blank_en=1): every zero digit above the most significant nonzero digit shows FF. Digit 0 is never blanked. Blanking does not affect bcd_out.
- Overflow: overflow=1; hex_out shows BF on every digit; bcd_out holds the truncated low DIGITS digits. The next conversion clears overflow if in range.
- Reset mid-conversion: abort immediately; all outputs return to reset values; no done pulse.
- reset and start in the same cycle: reset wins.

Optional Feature:
Macro SEG_SIGNED_EN.
- Defined:
  - bin_in is two's complement and the magnitude is converted.
  - Magnitude of the most negative value is 2^(BIN_W-1), handled without wrap.
  - Extra output neg (1 bit, reset 0) is registered in LOAD.
  - Magnitude uses the low DIGITS-1 digits. The top digit shows BF when negative and FF otherwise; its bcd_out nibble is 0.
  - Magnitude >= 10^(DIGITS-1) sets overflow.
- Not defined: unsigned operation as above; no neg port.

Test Plan:
- Reset asserted for 2 cycles -> ready=1, done=0, overflow=0, bcd_out=0, hex_out=40'hFFFFFFFFFF.
- Defaults: bin_in=1234, blank_en=1, start pulse -> done exactly 17 cycles after acceptance; bcd_out=20'h01234; hex_out digits 4..0 = FF,F9,A4,B0,99.
- bin_in=0 with blank_en=1 -> hex_out=FF,FF,FF,FF,C0. Repeat with blank_en=0 -> all five digits C0.
- bin_in=65535, start held high throughout, bin_in changed to 7 mid-conversion -> single done; bcd_out=20'h65535; the next conversion (7) starts only after ready returns.
- DIGITS=4, bin_in=12345 -> overflow=1, hex_out all BF, bcd_out=16'h2345. Then bin_in=9999 -> overflow=0, bcd_out=16'h9999.
- reset pulsed 5 cycles into a conversion -> no done; outputs at reset values; ready=1 the following cycle. With SEG_SIGNED_EN, bin_in=16'hFF85 (-123) -> neg=1, hex_out=BF,FF,F9,A4,B0.

Source files
------------

// File: rtl/bcd_seg_display_if.sv
// Handshake and display bus between a host and bcd_seg_display.
// With SEG_SIGNED_EN defined the bus also carries the neg sign flag.
interface bcd_seg_display_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic [BIN_W-1:0]    bin_in;
  logic                start;
  logic                blank_en;
  logic                ready;
  logic                done;
  logic                overflow;
  logic [4*DIGITS-1:0] bcd_out;
  logic [8*DIGITS-1:0] hex_out;
`ifdef SEG_SIGNED_EN
  logic                neg;

  modport master (
    output bin_in, start, blank_en,
    input  ready, done, overflow, bcd_out, hex_out, neg
  );
  modport slave (
    input  bin_in, start, blank_en,
    output ready, done, overflow, bcd_out, hex_out, neg
  );
`else
  modport master (
    output bin_in, start, blank_en,
    input  ready, done, overflow, bcd_out, hex_out
  );
  modport slave (
    input  bin_in, start, blank_en,
    output ready, done, overflow, bcd_out, hex_out
  );
`endif
endinterface

// File: rtl/bcd_seg_display.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS seven-segment displays.
// Optional macro SEG_SIGNED_EN: two's-complement input, sign shown on the top digit.
module bcd_seg_display #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset,
  bcd_seg_display_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BIN_W-1:0]    bin_r;
  logic [BIN_W-1:0]    mag_s;
  logic [SCR_W-1:0]    scr_r;
  logic [SCR_W-1:0]    adj_s;
  logic [SCR_W-1:0]    bcd_fin_s;
  logic [SCR_W-1:0]    bcd_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_r;
  logic                blank_r;
  logic                ovf_fin_s;
  logic                seen_s;
  logic [8*DIGITS-1:0] hex_fin_s;
  logic [8*DIGITS-1:0] hex_r;
  logic                ready_r;
  logic                done_r;
  logic                overflow_r;
`ifdef SEG_SIGNED_EN
  logic                neg_s;
  logic                neg_r;
  logic                neg_out_r;
`endif

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      else                     r[4*k +: 4] = s[4*k +: 4];
    end
    return r;
  endfunction

  // Value to convert: magnitude of the input in signed mode, raw input otherwise.
  always_comb begin
`ifdef SEG_SIGNED_EN
    neg_s = bus.bin_in[BIN_W-1];
    if (neg_s) mag_s = ~bus.bin_in + BIN_W'(1);
    else       mag_s = bus.bin_in;
`else
    mag_s = bus.bin_in;
`endif
  end

  // Digit adjust for the next shift and the final result seen in LOAD.
  always_comb begin
    adj_s = add3(scr_r);
`ifdef SEG_SIGNED_EN
    // The top digit is reserved for the sign, so any magnitude reaching it overflows.
    ovf_fin_s = ovf_r | (scr_r[SCR_W-1 -: 4] != 4'd0);
    bcd_fin_s = {4'd0, scr_r[SCR_W-5:0]};
`else
    ovf_fin_s = ovf_r;
    bcd_fin_s = scr_r;
`endif
  end

  // Segment encoding with leading-zero blanking, scanned from the top digit down.
  always_comb begin
    hex_fin_s = '1;
    seen_s    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (ovf_fin_s) hex_fin_s[8*k +: 8] = 8'hBF;
`ifdef SEG_SIGNED_EN
      else if (k == DIGITS - 1) hex_fin_s[8*k +: 8] = neg_r ? 8'hBF : 8'hFF;
`endif
      else if (blank_r && !seen_s && (k != 0) && (bcd_fin_s[4*k +: 4] == 4'd0))
        hex_fin_s[8*k +: 8] = 8'hFF;
      else
        hex_fin_s[8*k +: 8] = seg7(bcd_fin_s[4*k +: 4]);
      if (bcd_fin_s[4*k +: 4] != 4'd0) seen_s = 1'b1;
      else                             seen_s = seen_s;
    end
  end

  // FSM state register.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = SHIFT;
        else           state_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(1)) state_s = LOAD;
        else                    state_s = SHIFT;
      end
      LOAD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion datapath and registered outputs.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      bin_r      <= '0;
      scr_r      <= '0;
      cnt_r      <= '0;
      ovf_r      <= 1'b0;
      blank_r    <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      bcd_r      <= '0;
      hex_r      <= '1;
`ifdef SEG_SIGNED_EN
      neg_r      <= 1'b0;
      neg_out_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            bin_r   <= mag_s;
            scr_r   <= '0;
            cnt_r   <= CNT_W'(BIN_W);
            ovf_r   <= 1'b0;
            blank_r <= bus.blank_en;
            ready_r <= 1'b0;
`ifdef SEG_SIGNED_EN
            neg_r   <= neg_s;
`endif
          end else begin
            ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          scr_r <= {adj_s[SCR_W-2:0], bin_r[BIN_W-1]};
          bin_r <= {bin_r[BIN_W-2:0], 1'b0};
          ovf_r <= ovf_r | adj_s[SCR_W-1];
          cnt_r <= cnt_r - CNT_W'(1);
        end
        LOAD: begin
          bcd_r      <= bcd_fin_s;
          hex_r      <= hex_fin_s;
          overflow_r <= ovf_fin_s;
          done_r     <= 1'b1;
          ready_r    <= 1'b1;
`ifdef SEG_SIGNED_EN
          neg_out_r  <= neg_r;
`endif
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = ready_r;
  assign bus.done     = done_r;
  assign bus.overflow = overflow_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.hex_out  = hex_r;
`ifdef SEG_SIGNED_EN
  assign bus.neg      = neg_out_r;
`endif

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: a 5-digit and a 4-digit instance share
// stimulus and are compared against an arithmetic decimal model.
module tb_bcd_seg_display;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_seg_display_if #(.BIN_W(16), .DIGITS(5)) b5 ();
  bcd_seg_display_if #(.BIN_W(16), .DIGITS(4)) b4 ();

  bcd_seg_display #(.BIN_W(16), .DIGITS(5)) dut5 (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .bus          (b5)
  );
  bcd_seg_display #(.BIN_W(16), .DIGITS(4)) dut4 (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .bus          (b4)
  );

  logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: digits by division, blanking by position of the top nonzero digit.
  function automatic void model(input int v, input int d, input bit blank,
                                output logic [31:0] bcd, output logic [63:0] hex,
                                output bit ovf, output bit neg);
    int     mag;
    int     nd;
    int     msnz;
    longint lim;
    longint p;
    int     dg [8];
    neg = 1'b0;
    mag = v;
    nd  = d;
`ifdef SEG_SIGNED_EN
    if (v >= 32768) begin
      neg = 1'b1;
      mag = 65536 - v;
    end
    nd = d - 1;
`endif
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf  = (mag >= lim);
    bcd  = '0;
    hex  = '1;
    msnz = 0;
    p    = 1;
    for (int k = 0; k < 8; k++) begin
      dg[k] = (k < nd) ? int'((mag / p) % 10) : 0;
      p = p * 10;
      bcd[4*k +: 4] = 4'(dg[k]);
      if (dg[k] != 0) msnz = k;
    end
    for (int k = 0; k < d; k++) begin
      if (ovf)                   hex[8*k +: 8] = 8'hBF;
      else if (k >= nd)          hex[8*k +: 8] = neg ? 8'hBF : 8'hFF;
      else if (blank && k > msnz) hex[8*k +: 8] = 8'hFF;
      else                       hex[8*k +: 8] = seg_lut[dg[k]];
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (b5.ready !== 1'b1 || b5.done !== 1'b0 || b5.overflow !== 1'b0 ||
        b5.bcd_out !== 20'h0 || b5.hex_out !== 40'hFFFFFFFFFF) begin
      errors++;
      $display("FAIL reset5 got rdy=%b done=%b ovf=%b bcd=%h hex=%h exp 1 0 0 00000 FFFFFFFFFF",
               b5.ready, b5.done, b5.overflow, b5.bcd_out, b5.hex_out);
    end
    checks++;
    if (b4.ready !== 1'b1 || b4.done !== 1'b0 || b4.overflow !== 1'b0 ||
        b4.bcd_out !== 16'h0 || b4.hex_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset4 got rdy=%b done=%b ovf=%b bcd=%h hex=%h exp 1 0 0 0000 FFFFFFFF",
               b4.ready, b4.done, b4.overflow, b4.bcd_out, b4.hex_out);
    end
    reset = 1'b0;
    tick();
  endtask

  // One full conversion on both instances, checked against the model.
  task automatic test_convert(input string name, input int v, input bit blank);
    int          cyc;
    logic [31:0] eb5, eb4;
    logic [63:0] eh5, eh4;
    bit          eo5, eo4, en5, en4;
    cyc = 0;
    while (!(b5.ready === 1'b1 && b4.ready === 1'b1) && cyc < 40) begin
      tick();
      cyc++;
    end
    b5.bin_in = 16'(v);  b4.bin_in = 16'(v);
    b5.blank_en = blank; b4.blank_en = blank;
    b5.start = 1'b1;     b4.start = 1'b1;
    tick();
    b5.start = 1'b0;     b4.start = 1'b0;
    b5.bin_in = 16'($urandom); b4.bin_in = b5.bin_in;
    b5.blank_en = ~blank; b4.blank_en = ~blank;
    checks++;
    if (b5.ready !== 1'b0 || b4.ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_drop got %b/%b exp 0/0", name, b5.ready, b4.ready);
    end
    cyc = 0;
    while (b5.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL %s latency got %0d exp 17", name, cyc);
    end
    checks++;
    if (b4.done !== 1'b1 || b5.ready !== 1'b1 || b4.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done_ready got done4=%b rdy5=%b rdy4=%b exp 1 1 1",
               name, b4.done, b5.ready, b4.ready);
    end
    model(v, 5, blank, eb5, eh5, eo5, en5);
    model(v, 4, blank, eb4, eh4, eo4, en4);
    checks++;
    if (b5.bcd_out !== eb5[19:0] || b5.hex_out !== eh5[39:0] || b5.overflow !== eo5) begin
      errors++;
      $display("FAIL %s out5 got bcd=%h hex=%h ovf=%b exp bcd=%h hex=%h ovf=%b",
               name, b5.bcd_out, b5.hex_out, b5.overflow, eb5[19:0], eh5[39:0], eo5);
    end
    checks++;
    if (b4.bcd_out !== eb4[15:0] || b4.hex_out !== eh4[31:0] || b4.overflow !== eo4) begin
      errors++;
      $display("FAIL %s out4 got bcd=%h hex=%h ovf=%b exp bcd=%h hex=%h ovf=%b",
               name, b4.bcd_out, b4.hex_out, b4.overflow, eb4[15:0], eh4[31:0], eo4);
    end
`ifdef SEG_SIGNED_EN
    checks++;
    if (b5.neg !== en5 || b4.neg !== en4) begin
      errors++;
      $display("FAIL %s neg got %b/%b exp %b/%b", name, b5.neg, b4.neg, en5, en4);
    end
`endif
    tick();
    checks++;
    if (b5.done !== 1'b0 || b4.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got %b/%b exp 0/0", name, b5.done, b4.done);
    end
  endtask

  task automatic test_defaults();
    test_convert("dec1234", 1234, 1'b1);
    checks++;
    if (b5.bcd_out !== 20'h01234 || b5.hex_out !== 40'hFFF9A4B099) begin
      errors++;
      $display("FAIL dec1234_const got bcd=%h hex=%h exp 01234 FFF9A4B099", b5.bcd_out, b5.hex_out);
    end
    test_convert("zero_blank", 0, 1'b1);
    test_convert("zero_noblank", 0, 1'b0);
`ifndef SEG_SIGNED_EN
    checks++;
    if (b5.hex_out !== 40'hC0C0C0C0C0) begin
      errors++;
      $display("FAIL zero_noblank_const got %h exp C0C0C0C0C0", b5.hex_out);
    end
`endif
  endtask

  task automatic test_overflow();
    test_convert("ovf12345", 12345, 1'b1);
`ifndef SEG_SIGNED_EN
    checks++;
    if (b4.overflow !== 1'b1 || b4.hex_out !== 32'hBFBFBFBF || b4.bcd_out !== 16'h2345) begin
      errors++;
      $display("FAIL ovf12345_const got ovf=%b hex=%h bcd=%h exp 1 BFBFBFBF 2345",
               b4.overflow, b4.hex_out, b4.bcd_out);
    end
`endif
    test_convert("in9999", 9999, 1'b0);
`ifndef SEG_SIGNED_EN
    checks++;
    if (b4.overflow !== 1'b0 || b4.bcd_out !== 16'h9999) begin
      errors++;
      $display("FAIL in9999_const got ovf=%b bcd=%h exp 0 9999", b4.overflow, b4.bcd_out);
    end
`endif
  endtask

  // start held high through a conversion: no requeue, next value taken only once ready returns.
  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] eb5, eb4;
    logic [63:0] eh5, eh4;
    bit          eo5, eo4, en5, en4;
    b5.bin_in = 16'd65535; b4.bin_in = 16'd65535;
    b5.blank_en = 1'b1;    b4.blank_en = 1'b1;
    b5.start = 1'b1;       b4.start = 1'b1;
    tick();
    cyc = 0;
    while (b5.done !== 1'b1 && cyc < 40) begin
      if (cyc == 5) begin
        b5.bin_in = 16'd7;
        b4.bin_in = 16'd7;
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL hold_latency got %0d exp 17", cyc);
    end
    model(65535, 5, 1'b1, eb5, eh5, eo5, en5);
    model(65535, 4, 1'b1, eb4, eh4, eo4, en4);
    checks++;
    if (b5.bcd_out !== eb5[19:0] || b5.hex_out !== eh5[39:0] ||
        b4.bcd_out !== eb4[15:0] || b4.overflow !== eo4) begin
      errors++;
      $display("FAIL hold_65535 got bcd5=%h hex5=%h bcd4=%h ovf4=%b exp %h %h %h %b",
               b5.bcd_out, b5.hex_out, b4.bcd_out, b4.overflow, eb5[19:0], eh5[39:0], eb4[15:0], eo4);
    end
    tick();
    checks++;
    if (b5.done !== 1'b0 || b5.ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_reaccept got done=%b ready=%b exp 0 0", b5.done, b5.ready);
    end
    b5.start = 1'b0; b4.start = 1'b0;
    cyc = 0;
    while (b5.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    model(7, 5, 1'b1, eb5, eh5, eo5, en5);
    checks++;
    if (cyc != 17 || b5.bcd_out !== eb5[19:0] || b5.hex_out !== eh5[39:0]) begin
      errors++;
      $display("FAIL hold_second got cyc=%0d bcd=%h hex=%h exp 17 %h %h",
               cyc, b5.bcd_out, b5.hex_out, eb5[19:0], eh5[39:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    b5.bin_in = 16'd4321; b4.bin_in = 16'd4321;
    b5.start = 1'b1;      b4.start = 1'b1;
    tick();
    b5.start = 1'b0;      b4.start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (b5.ready !== 1'b1 || b5.done !== 1'b0 || b5.overflow !== 1'b0 ||
        b5.bcd_out !== 20'h0 || b5.hex_out !== 40'hFFFFFFFFFF ||
        b4.bcd_out !== 16'h0 || b4.hex_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b done=%b ovf=%b bcd5=%h hex5=%h bcd4=%h hex4=%h exp reset values",
               b5.ready, b5.done, b5.overflow, b5.bcd_out, b5.hex_out, b4.bcd_out, b4.hex_out);
    end
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (b5.done === 1'b1 || b4.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_nodone got %0d done pulses exp 0", dones);
    end
  endtask

`ifdef SEG_SIGNED_EN
  task automatic test_signed();
    test_convert("neg123", 16'hFF85, 1'b1);
    checks++;
    if (b5.neg !== 1'b1 || b5.hex_out !== 40'hBFFFF9A4B0) begin
      errors++;
      $display("FAIL neg123_const got neg=%b hex=%h exp 1 BFFFF9A4B0", b5.neg, b5.hex_out);
    end
    test_convert("most_neg", 16'h8000, 1'b1);
    test_convert("pos_max", 16'h7FFF, 1'b0);
  endtask
`endif

  task automatic test_random();
    int v;
    for (int n = 0; n < 30; n++) begin
      v = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      test_convert("random", v, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    b5.bin_in = '0; b5.start = 1'b0; b5.blank_en = 1'b0;
    b4.bin_in = '0; b4.start = 1'b0; b4.blank_en = 1'b0;
    test_reset();
    test_defaults();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef SEG_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
